// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch sequencer: FSM state encoding,
// next-pc select codes and the sequential pc increment.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      SEL_HOLD  = 2'd0,
      SEL_INC   = 2'd1,
      SEL_REDIR = 2'd2
   } pc_sel_t;

   localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-pc selection: hold pc, advance by PC_INC, or take the
// redirect address (branch target, or TRAP_PC when the target is misaligned).
module pc_next_sel
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] TRAP_PC = 32'h0000_0100
) (
   input  logic [1:0]  sel,
   input  logic [31:0] pc,
   input  logic [31:0] target,
   input  logic        use_trap,
   output logic [31:0] pc_next
);

   always_comb begin
      pc_next = pc;
      case (sel)
         SEL_INC:   pc_next = pc + PC_INC;
         SEL_REDIR: pc_next = use_trap ? TRAP_PC : target;
         default:   pc_next = pc;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: IDLE/FETCH/HOLD/FLUSH FSM driving the imem
// request and the fetched-instruction register. Optional macro MISALIGN_TRAP_EN.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch,
   input  logic        cond,
   input  logic [31:0] target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        flush,
   output logic        misalign_trap
);

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [31:0] instr_reg, instr_pc_reg;
   logic        instr_valid_reg, valid_next;
   logic        capture, redirect, misaligned;
   logic [1:0]  sel;

   // Redirects are only honoured while a fetch is outstanding or held.
   assign redirect = branch & cond & ((state_reg == ST_FETCH) || (state_reg == ST_HOLD));

`ifdef MISALIGN_TRAP_EN
   logic trap_reg;

   assign misaligned = |target[1:0];

   always_ff @(posedge clk) begin
      if (rst) trap_reg <= 1'b0;
      else     trap_reg <= redirect & misaligned;
   end

   assign misalign_trap = (state_reg == ST_FLUSH) & trap_reg;
`else
   assign misaligned    = 1'b0;
   assign misalign_trap = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      sel        = SEL_HOLD;
      valid_next = 1'b0;
      capture    = 1'b0;
      case (state_reg)
         ST_IDLE: state_next = ST_FETCH;
         ST_FETCH: begin
            if (redirect) begin
               sel        = SEL_REDIR;
               state_next = ST_FLUSH;
            end else if (imem_ack) begin
               capture    = 1'b1;
               valid_next = 1'b1;
               if (stall) state_next = ST_HOLD;
               else       sel        = SEL_INC;
            end
         end
         ST_HOLD: begin
            if (redirect) begin
               sel        = SEL_REDIR;
               state_next = ST_FLUSH;
            end else if (!stall) begin
               sel        = SEL_INC;
               state_next = ST_FETCH;
            end else begin
               valid_next = instr_valid_reg;
            end
         end
         ST_FLUSH: state_next = ST_FETCH;
         default:  state_next = ST_IDLE;
      endcase
   end

   pc_next_sel #(
      .TRAP_PC (TRAP_PC)
   ) u_pc_next_sel (
      .sel      (sel),
      .pc       (pc_reg),
      .target   (target),
      .use_trap (misaligned),
      .pc_next  (pc_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         pc_reg          <= RESET_PC;
         instr_reg       <= '0;
         instr_pc_reg    <= '0;
         instr_valid_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         pc_reg          <= pc_next;
         instr_valid_reg <= valid_next;
         if (capture) begin
            instr_reg    <= imem_rdata;
            instr_pc_reg <= pc_reg;
         end
      end
   end

   assign imem_req    = (state_reg == ST_FETCH);
   assign imem_addr   = pc_reg;
   assign flush       = (state_reg == ST_FLUSH);
   assign instr_valid = instr_valid_reg;
   assign instr       = instr_reg;
   assign instr_pc    = instr_pc_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer: each row drives one cycle of inputs and
// pushes the outputs expected in that cycle; a checker pops and compares them.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst, stall, branch, cond, imem_ack;
   logic [31:0] target, imem_rdata;
   logic        imem_req, instr_valid, flush, misalign_trap;
   logic [31:0] imem_addr, instr, instr_pc;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch        (branch),
      .cond          (cond),
      .target        (target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr_valid   (instr_valid),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .flush         (flush),
      .misalign_trap (misalign_trap)
   );

   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] instr;
      logic [31:0] ipc;
      logic        flush;
      logic        trap;
   } out_t;

   typedef struct {
      logic        rst, stall, branch, cond, ack;
      logic [31:0] target, rdata;
      out_t        exp;
   } vec_t;

   typedef struct {
      int   id;
      out_t exp;
   } sb_t;

   localparam logic [31:0] D0 = 32'h0000_0013, D1 = 32'h0010_0093, D2 = 32'h0020_0113;
   localparam logic [31:0] D3 = 32'h0030_0193, D4 = 32'h0040_0213, D5 = 32'h0050_0293;
   localparam logic [31:0] D6 = 32'h0060_0313, D7 = 32'h0070_0393, D8 = 32'h0080_0413;
   localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
`ifdef MISALIGN_TRAP_EN
   localparam logic [31:0] MIS_PC = 32'h0000_0100;
   localparam logic        MIS_TRAP = 1'b1;
`else
   localparam logic [31:0] MIS_PC = 32'h0000_0042;
   localparam logic        MIS_TRAP = 1'b0;
`endif

   vec_t vecs[$];
   sb_t  sb_q[$];
   int   checks = 0;
   int   failures = 0;

   function automatic vec_t mk(input logic r, s, b, c, a, input logic [31:0] t, d,
                               input logic req, input logic [31:0] addr, input logic v,
                               input logic [31:0] ins, ipc, input logic fl, tr);
      vec_t x;
      x.rst = r; x.stall = s; x.branch = b; x.cond = c; x.ack = a;
      x.target = t; x.rdata = d;
      x.exp = '{req: req, addr: addr, valid: v, instr: ins, ipc: ipc, flush: fl, trap: tr};
      return x;
   endfunction

   task automatic drive(input vec_t x, input int id);
      sb_t e;
      @(posedge clk);
      #1;
      rst = x.rst; stall = x.stall; branch = x.branch; cond = x.cond;
      imem_ack = x.ack; target = x.target; imem_rdata = x.rdata;
      e.id = id;
      e.exp = x.exp;
      sb_q.push_back(e);
   endtask

   task automatic check_out();
      sb_t  e;
      out_t act;
      @(negedge clk);
      if (sb_q.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_empty: no expectation queued");
         return;
      end
      e = sb_q.pop_front();
      act = '{req: imem_req, addr: imem_addr, valid: instr_valid, instr: instr,
              ipc: instr_pc, flush: flush, trap: misalign_trap};
      checks++;
      if (act !== e.exp) begin
         failures++;
         $display("FAIL txn_%0d: got req=%b addr=%h valid=%b instr=%h ipc=%h flush=%b trap=%b, want req=%b addr=%h valid=%b instr=%h ipc=%h flush=%b trap=%b",
                  e.id, act.req, act.addr, act.valid, act.instr, act.ipc, act.flush, act.trap,
                  e.exp.req, e.exp.addr, e.exp.valid, e.exp.instr, e.exp.ipc, e.exp.flush, e.exp.trap);
      end else begin
         $display("txn %0d ok: req=%b addr=%h valid=%b instr=%h ipc=%h flush=%b trap=%b",
                  e.id, act.req, act.addr, act.valid, act.instr, act.ipc, act.flush, act.trap);
      end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; branch = 1'b0; cond = 1'b0; imem_ack = 1'b0;
      target = '0; imem_rdata = '0;

      //        rst s b c ack target        rdata  | req addr          v instr ipc          fl trap
      vecs.push_back(mk(1,0,0,0,0, 32'h0,        '0,   0, 32'h0,        0, '0, 32'h0,        0, 0));
      vecs.push_back(mk(0,0,0,0,0, 32'h0,        '0,   0, 32'h0,        0, '0, 32'h0,        0, 0));
      vecs.push_back(mk(0,0,0,0,1, 32'h0,        D0,   1, 32'h0,        0, '0, 32'h0,        0, 0));
      vecs.push_back(mk(0,0,0,0,1, 32'h0,        D1,   1, 32'h4,        1, D0, 32'h0,        0, 0));
      vecs.push_back(mk(0,1,0,0,1, 32'h0,        D2,   1, 32'h8,        1, D1, 32'h4,        0, 0));
      vecs.push_back(mk(0,1,0,0,0, 32'h0,        '0,   0, 32'h8,        1, D2, 32'h8,        0, 0));
      vecs.push_back(mk(0,1,0,0,1, 32'h0,        JUNK, 0, 32'h8,        1, D2, 32'h8,        0, 0));
      vecs.push_back(mk(0,0,0,0,0, 32'h0,        '0,   0, 32'h8,        1, D2, 32'h8,        0, 0));
      vecs.push_back(mk(0,0,1,0,0, 32'h80,       '0,   1, 32'hC,        0, D2, 32'h8,        0, 0));
      vecs.push_back(mk(0,0,1,0,1, 32'h80,       D3,   1, 32'hC,        0, D2, 32'h8,        0, 0));
      vecs.push_back(mk(0,0,1,1,1, 32'h40,       JUNK, 1, 32'h10,       1, D3, 32'hC,        0, 0));
      vecs.push_back(mk(0,0,1,1,1, 32'h80,       JUNK, 0, 32'h40,       0, D3, 32'hC,        1, 0));
      vecs.push_back(mk(0,0,0,0,0, 32'h0,        '0,   1, 32'h40,       0, D3, 32'hC,        0, 0));
      vecs.push_back(mk(0,1,0,0,1, 32'h0,        D4,   1, 32'h40,       0, D3, 32'hC,        0, 0));
      vecs.push_back(mk(0,1,1,1,0, 32'h42,       '0,   0, 32'h40,       1, D4, 32'h40,       0, 0));
      vecs.push_back(mk(0,0,0,0,0, 32'h0,        '0,   0, MIS_PC,       0, D4, 32'h40,       1, MIS_TRAP));
      vecs.push_back(mk(0,1,0,0,1, 32'h0,        D5,   1, MIS_PC,       0, D4, 32'h40,       0, 0));
      vecs.push_back(mk(1,1,0,0,0, 32'h0,        '0,   0, MIS_PC,       1, D5, MIS_PC,       0, 0));
      vecs.push_back(mk(0,1,0,0,1, 32'h0,        JUNK, 0, 32'h0,        0, '0, 32'h0,        0, 0));
      vecs.push_back(mk(1,0,0,0,1, 32'h0,        D6,   1, 32'h0,        0, '0, 32'h0,        0, 0));
      vecs.push_back(mk(0,0,0,0,0, 32'h0,        '0,   0, 32'h0,        0, '0, 32'h0,        0, 0));
      vecs.push_back(mk(0,0,0,0,1, 32'h0,        D7,   1, 32'h0,        0, '0, 32'h0,        0, 0));
      vecs.push_back(mk(0,0,0,0,0, 32'h0,        '0,   1, 32'h4,        1, D7, 32'h0,        0, 0));
      vecs.push_back(mk(0,0,0,0,0, 32'h0,        '0,   1, 32'h4,        0, D7, 32'h0,        0, 0));
      vecs.push_back(mk(0,0,1,1,0, 32'hFFFFFFFC, '0,   1, 32'h4,        0, D7, 32'h0,        0, 0));
      vecs.push_back(mk(0,0,0,0,0, 32'h0,        '0,   0, 32'hFFFFFFFC, 0, D7, 32'h0,        1, 0));
      vecs.push_back(mk(0,0,0,0,1, 32'h0,        D8,   1, 32'hFFFFFFFC, 0, D7, 32'h0,        0, 0));
      vecs.push_back(mk(0,0,0,0,0, 32'h0,        '0,   1, 32'h0,        1, D8, 32'hFFFFFFFC, 0, 0));

      @(posedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i], i);
         check_out();
      end

      // Redirect beats a simultaneous stall and ack; stall is ignored in FLUSH.
      drive(mk(0,1,1,1,1, 32'h200, JUNK, 1, 32'h0,   0, D8, 32'hFFFFFFFC, 0, 0), 100);
      check_out();
      drive(mk(0,1,0,0,1, 32'h0,   JUNK, 0, 32'h200, 0, D8, 32'hFFFFFFFC, 1, 0), 101);
      check_out();
      drive(mk(0,0,0,0,0, 32'h0,   '0,   1, 32'h200, 0, D8, 32'hFFFFFFFC, 0, 0), 102);
      check_out();

      // Plain redirect on an idle FETCH, then a fetch at the new address.
      drive(mk(0,0,1,1,0, 32'h300, '0,   1, 32'h200, 0, D8, 32'hFFFFFFFC, 0, 0), 103);
      check_out();
      drive(mk(0,0,0,0,0, 32'h0,   '0,   0, 32'h300, 0, D8, 32'hFFFFFFFC, 1, 0), 104);
      check_out();
      drive(mk(0,0,0,0,1, 32'h0,   D0,   1, 32'h300, 0, D8, 32'hFFFFFFFC, 0, 0), 105);
      check_out();
      drive(mk(0,0,0,0,0, 32'h0,   '0,   1, 32'h304, 1, D0, 32'h300,      0, 0), 106);
      check_out();

      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h00000000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter TRAP_PC, default 32'h00000100, meaning the redirect address for a misaligned branch target.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; the ports are clk and rst.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 stall  in  1  downstream cannot accept an instruction; hold the current one.
REQ-007 branch  in  1  decoded instruction is a branch or jump.
REQ-008 cond  in  1  branch condition true; redirect = branch AND cond.
REQ-009 target  in  32  branch or jump target address.
REQ-010 imem_req  out  1  instruction-memory fetch request.
REQ-011 imem_addr  out  32  fetch address; equals pc.
REQ-012 imem_ack  in  1  memory returns imem_rdata this cycle.
REQ-013 imem_rdata  in  32  fetched instruction word.
REQ-014 instr_valid  out  1  instr/instr_pc hold a valid instruction.
REQ-015 instr  out  32  fetched instruction.
REQ-016 instr_pc  out  32  address of instr.
REQ-017 flush  out  1  one-cycle pulse; younger pipeline state must be discarded.
REQ-018 misalign_trap  out  1  one-cycle pulse on a misaligned redirect target.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, HOLD and FLUSH, encoded as a 2-bit enum.
REQ-020 IDLE SHALL drive imem_req=0 and SHALL transition to FETCH on the next cycle.
REQ-021 FETCH SHALL drive imem_req=1 and imem_addr=pc, holding both stable until imem_ack or a redirect.
REQ-022 In FETCH, an ack with stall=0 SHALL: register instr<=imem_rdata and instr_pc<=pc; set instr_valid=1 for the next cycle; set pc<=pc+4 (modulo 2^32); remain in FETCH.
REQ-023 In FETCH, an ack with stall=1 SHALL register instr and instr_pc, set instr_valid=1, and enter HOLD with pc unchanged.
REQ-024 In HOLD, imem_req=0 and instr, instr_pc and instr_valid SHALL remain stable; when stall falls, pc<=pc+4, instr_valid<=0 and the next state is FETCH.
REQ-025 In FETCH without ack, instr_valid SHALL be 0 in the following cycle.
REQ-026 Redirect (branch&cond) sampled in FETCH or HOLD SHALL:
- set pc<=target;
- discard any same-cycle ack;
- set instr_valid<=0;
- enter FLUSH.
REQ-027 Redirect SHALL take priority over stall and over ack.
REQ-028 FLUSH SHALL drive flush=1, imem_req=0 and instr_valid=0 for exactly one cycle, then go to FETCH.
REQ-029 Redirect in IDLE or FLUSH SHALL be ignored.
REQ-030 Fetch latency SHALL be 1 cycle from imem_ack to instr_valid.
REQ-031 Redirect-to-new-request latency SHALL be 2 cycles.

Reset
REQ-032 Reset SHALL take priority over all inputs, including reset asserted mid-fetch or mid-stall.
REQ-033 On reset: state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, flush=0, misalign_trap=0.
REQ-034 Any ack arriving during reset SHALL be discarded.

Configuration
REQ-035 Macro MISALIGN_TRAP_EN defined: a redirect with target[1:0]!=0 SHALL set pc<=TRAP_PC (not target) and pulse misalign_trap together with flush in FLUSH.
REQ-036 Macro MISALIGN_TRAP_EN undefined: target SHALL be used unchanged and misalign_trap SHALL be tied 0.

Structure
REQ-037 Package pc_seq_pkg SHALL hold the state enum and the constant PC_INC=4.
REQ-038 Sub-module pc_next_sel SHALL be combinational 3-way next-pc selection: pc, pc+4, or redirect address (target or TRAP_PC).

Verification
REQ-039 Reset, then ack immediately -> imem_addr 0x00000000; instr_valid=1 one cycle later; next imem_addr 0x00000004.
REQ-040 Ack at pc 0x8 with stall=1 for 3 cycles -> instr_pc=0x8 stable, imem_req=0 during stall; after release imem_addr=0xC.
REQ-041 Branch=1, cond=1, target 0x40 with simultaneous ack -> ack data dropped; flush=1 next cycle; imem_addr=0x40 the cycle after.
REQ-042 Branch=1, cond=0 -> no flush; sequential pc+4 continues.
REQ-043 With MISALIGN_TRAP_EN, target 0x42 -> misalign_trap=1 and flush=1 together; next imem_addr=0x100. Without the macro -> imem_addr=0x42, trap 0.
REQ-044 rst asserted during HOLD with stall=1 -> next cycle state IDLE, instr_valid=0, pc=RESET_PC.
